// File: rtl/bitonic_pkg.sv
// Shared helpers for the pipelined bitonic sorter: layer counts and the per-layer
// wiring map (partner index and network direction of every element).
package bitonic_pkg;

    typedef struct packed {
        int unsigned partner;
        logic        is_low;
        logic        net_descend;
    } cas_map_t;

    function automatic int unsigned log_n(input int unsigned n);
        return $clog2(n);
    endfunction

    function automatic int unsigned n_layers(input int unsigned n);
        int unsigned lg;
        lg = $clog2(n);
        return (lg * (lg + 1)) / 2;
    endfunction

    // Layers are numbered in network order: merge size 2^s (s = 1..LOG_N), and inside
    // each merge the compare distance halves from 2^(s-1) down to 1.
    function automatic cas_map_t cas_map(input int unsigned n,
                                         input int unsigned layer,
                                         input int unsigned elem);
        cas_map_t    m;
        int unsigned lg;
        int unsigned idx;
        int unsigned d;
        m   = '0;
        lg  = $clog2(n);
        idx = 0;
        for (int unsigned s = 1; s <= lg; s++) begin
            for (int j = int'(s) - 1; j >= 0; j--) begin
                if (idx == layer) begin
                    d             = 32'd1 << j;
                    m.partner     = elem ^ d;
                    m.is_low      = ((elem & d) == 0);
                    m.net_descend = (((elem >> s) & 32'd1) != 0);
                end
                idx++;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/bitonic_cas_layer.sv
// One combinational compare-and-swap layer of the bitonic network.
// BITONIC_SIGNED_EN selects two's-complement compare; default is unsigned.
module bitonic_cas_layer
    import bitonic_pkg::*;
#(
    parameter int unsigned N_ELEM = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LAYER  = 0
) (
    input  logic                           descend_i,
    input  logic [N_ELEM-1:0][DATA_W-1:0]  data_i,
    output logic [N_ELEM-1:0][DATA_W-1:0]  data_o
);

    for (genvar e = 0; e < N_ELEM; e++) begin : g_elem
        localparam cas_map_t    MAP     = cas_map(N_ELEM, LAYER, e);
        localparam int unsigned PARTNER = MAP.partner;

        logic [DATA_W-1:0] own;
        logic [DATA_W-1:0] other;
        logic              other_lt;
        logic              other_gt;
        logic              take_min;

        assign own   = data_i[e];
        assign other = data_i[PARTNER];

`ifdef BITONIC_SIGNED_EN
        assign other_lt = $signed(other) < $signed(own);
        assign other_gt = $signed(other) > $signed(own);
`else
        assign other_lt = other < own;
        assign other_gt = other > own;
`endif

        // Strict compares keep equal elements in place, so duplicates never swap.
        assign take_min  = MAP.is_low ^ MAP.net_descend ^ descend_i;
        assign data_o[e] = (take_min ? other_lt : other_gt) ? other : own;
    end

endmodule

// File: rtl/bitonic_sort_pipe.sv
// Fully pipelined bitonic sorter with valid/ready on both sides and per-vector
// ascending/descending mode. BITONIC_SIGNED_EN switches element compare to signed.
module bitonic_sort_pipe
    import bitonic_pkg::*;
#(
    parameter int unsigned N_ELEM = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic                           in_descend_i,
    input  logic [N_ELEM-1:0][DATA_W-1:0]  in_list_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [N_ELEM-1:0][DATA_W-1:0]  out_list_o,
    output logic                           busy_o
);

    localparam int N_LAYERS = int'(n_layers(N_ELEM));

    if (N_ELEM < 2 || (N_ELEM & (N_ELEM - 1)) != 0) begin : g_bad_n_elem
        $error("bitonic_sort_pipe: N_ELEM must be a power of two >= 2");
    end
    if (DATA_W < 1) begin : g_bad_data_w
        $error("bitonic_sort_pipe: DATA_W must be >= 1");
    end

    typedef logic [N_ELEM-1:0][DATA_W-1:0] vec_t;

    typedef struct packed {
        logic valid;
        logic descend;
        vec_t data;
    } stage_t;

    stage_t [N_LAYERS-1:0] stg;
    vec_t   [N_LAYERS-1:0] cas_in;
    vec_t   [N_LAYERS-1:0] cas_out;
    logic   [N_LAYERS-1:0] cas_desc;
    logic                  adv;

    // The whole pipe moves as one; only a stuck output word can stall it.
    assign adv         = !stg[N_LAYERS-1].valid || out_ready_i;
    assign in_ready_o  = adv;
    assign out_valid_o = stg[N_LAYERS-1].valid;
    assign out_list_o  = stg[N_LAYERS-1].data;

    always_comb begin
        cas_in      = '0;
        cas_desc    = '0;
        cas_in[0]   = in_list_i;
        cas_desc[0] = in_descend_i;
        for (int k = 1; k < N_LAYERS; k++) begin
            cas_in[k]   = stg[k-1].data;
            cas_desc[k] = stg[k-1].descend;
        end
    end

    for (genvar k = 0; k < N_LAYERS; k++) begin : g_layer
        bitonic_cas_layer #(
            .N_ELEM (N_ELEM),
            .DATA_W (DATA_W),
            .LAYER  (k)
        ) u_cas (
            .descend_i (cas_desc[k]),
            .data_i    (cas_in[k]),
            .data_o    (cas_out[k])
        );
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stg <= '0;
        end else if (adv) begin
            stg[0] <= '{valid: in_valid_i, descend: in_descend_i, data: cas_out[0]};
            for (int k = 1; k < N_LAYERS; k++) begin
                stg[k] <= '{valid: stg[k-1].valid, descend: stg[k-1].descend, data: cas_out[k]};
            end
        end
    end

    always_comb begin
        busy_o = 1'b0;
        for (int k = 0; k < N_LAYERS; k++) begin
            busy_o = busy_o | stg[k].valid;
        end
    end

endmodule
